// File: rtl/alu_pkg.sv
// Shared opcode constants, state encoding and request bundle for the ALU
// and the ALU request arbiter.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_MAX = OP_SHL;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        fin;
    } alu_req_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advances on accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    // ptr = 1 means requester 1 wins when both request
    logic ptr;

    // grant: a lone requester always wins, contention resolved by ptr
    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = ptr ? 2'b10 : 2'b01;
    end

    // after granting requester i, favour the other one next time
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (adv)
            ptr <= gnt[0];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared, externally instantiated ALU
// and returns one tagged response per accepted operation.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_fin,
    input  logic [3:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_fin,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_tag,
    output logic [31:0]      resp_result,
    output logic [3:0]       resp_flags,
    output logic             resp_err,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_ctrl,
    output logic             alu_flag_in,
    input  logic [31:0]      alu_result,
    input  logic [3:0]       alu_flags,
    output logic [CNT_W-1:0] op_count
);

    arb_state_t state, nxt;
    logic [1:0] gnt;
    logic       accept;
    logic       gsel;
    logic       hs;
    logic       legal;
    alu_req_t   sel;

    rr_arb2 u_rr (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .adv (accept),
        .gnt (gnt)
    );

    assign accept = |(req_valid & req_ready);
    assign gsel   = gnt[1];
    assign hs     = resp_valid & resp_ready;
    assign legal  = op_legal(sel.op);

    // mux the granted requester's operation
    always_comb begin
        sel = '{op: req0_op, a: req0_a, b: req0_b, fin: req0_fin};
        if (gsel)
            sel = '{op: req1_op, a: req1_a, b: req1_b, fin: req1_fin};
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    // next state: illegal ops skip the ALU cycle entirely
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (accept) nxt = legal ? ST_ISSUE : ST_RESP;
            ST_ISSUE: nxt = ST_RESP;
            ST_RESP:  if (hs) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // outputs: grant only offered in IDLE and never while reset is held
    always_comb begin
        req_ready  = (state == ST_IDLE && !rst) ? gnt : 2'b00;
        resp_valid = (state == ST_RESP);
    end

    // ALU operand registers; held through ISSUE and untouched by illegal ops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= '0;
            alu_flag_in <= 1'b0;
        end else if (state == ST_IDLE && accept && legal) begin
            alu_a       <= sel.a;
            alu_b       <= sel.b;
            alu_ctrl    <= sel.op;
            alu_flag_in <= sel.fin;
        end
    end

    // response registers: tag at accept, payload at end of ISSUE or error at accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_tag    <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
            resp_err    <= 1'b0;
        end else if (state == ST_IDLE && accept) begin
            resp_tag <= gsel;
            if (!legal) begin
                resp_err    <= 1'b1;
                resp_result <= '0;
                resp_flags  <= '0;
            end
        end else if (state == ST_ISSUE) begin
            resp_result <= alu_result;
            resp_flags  <= alu_flags;
            resp_err    <= 1'b0;
        end
    end

    // saturating count of completed legal operations
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op_count <= '0;
        else if (hs && !resp_err && op_count != {CNT_W{1'b1}})
            op_count <= op_count + CNT_W'(1);
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of completed-operation counter.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  2  per-requester request valid (bit i = requester i).
REQ-005 req_ready  out  2  per-requester accept; at most one bit high.
REQ-006 req0_op / req1_op  in  4  opcode: add 0, sub 1, inc 2, dec 3, and 4, or 5, not 6, xor 7, shr 8, shl 9.
REQ-007 req0_a, req0_b / req1_a, req1_b  in  32  operands.
REQ-008 req0_fin / req1_fin  in  1  flag-in value (carry-in, NOT select, shift fill).
REQ-009 resp_valid  out  1  response valid.
REQ-010 resp_ready  in  1  response consumer ready.
REQ-011 resp_tag  out  1  index of the requester that issued the operation.
REQ-012 resp_result  out  32;  resp_flags  out  4 [V,C,Z,N];  resp_err  out  1 illegal opcode.
REQ-013 alu_a, alu_b  out  32;  alu_ctrl  out  4;  alu_flag_in  out  1  drive the shared ALU.
REQ-014 alu_result  in  32;  alu_flags  in  4  from the shared ALU (registered on falling Clk).
REQ-015 op_count  out  CNT_W  completed legal operations, saturating.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-017 IDLE: if any req_valid, grant one requester; req_ready[grant] SHALL be high combinationally that cycle, all other bits low; accept = valid & ready.
REQ-018 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; single valid -> grant it; pointer updates only on accept.
REQ-019 On accept of legal op (0-9): latch op, a, b, fin into registers driving alu_* ports; go ISSUE.
REQ-020 ISSUE lasts exactly one cycle; alu_* ports SHALL hold stable; at its closing edge capture alu_result/alu_flags into resp_result/resp_flags, resp_err=0, go RESP.
REQ-021 Legal-op latency: resp_valid high 2 cycles after the accept edge.
REQ-022 Illegal op (A-F): accepted normally, ALU ports left unchanged, go directly to RESP with resp_err=1, resp_result=0, resp_flags=0; latency 1 cycle.
REQ-023 RESP: resp_valid=1, resp_* stable until resp_valid & resp_ready; then go IDLE; req_ready=0 throughout ISSUE and RESP.
REQ-024 op_count increments by 1 on each legal-op response handshake; holds at 2^CNT_W-1.
REQ-025 req_valid changes while not accepted SHALL have no effect on state.

Reset
REQ-026 Rst high SHALL immediately force IDLE, req_ready=0, resp_valid=0, resp_tag=0, resp_result=0, resp_flags=0, resp_err=0, alu_*=0, op_count=0, round-robin pointer favouring requester 0.
REQ-027 Reset during ISSUE or RESP discards the in-flight operation; no response is produced after release.
REQ-028 First grant after reset with both valid SHALL go to requester 0.

Structure
REQ-029 Opcode constants (OP_ADD..OP_SHL, OP_MAX=9) and state encodings SHALL live in a shared package alu_pkg used by this block and the ALU.
REQ-030 Round-robin grant logic SHALL be one sub-module rr_arb2 (2 requests, pointer, 2-bit one-hot grant); the ALU is instantiated outside this block.

Verification
REQ-031 Req0 add a=5 b=7 fin=0, resp_ready=1 -> accept cycle 0, resp_valid cycle 2, result 12, tag 0, err 0, op_count 1.
REQ-032 Both requesters valid continuously with legal ops -> grants 0,1,0,1; each grant separated by 3 cycles.
REQ-033 Req1 op 4'hC -> resp_valid 1 cycle after accept, err 1, result 0, flags 0, alu_ctrl unchanged, op_count unchanged.
REQ-034 Legal response with resp_ready low 5 cycles -> resp_* stable, req_ready=0 for all 5; handshake on cycle 6 then IDLE.
REQ-035 Rst pulsed during ISSUE -> same cycle outputs zero; after release no resp_valid until a new accept.
REQ-036 CNT_W=2, 5 legal ops -> op_count 1,2,3,3,3.
